// File: rtl/recip_div_pkg.sv
// Shared constants and types for the reciprocal-based quotient unit.
//   ARG_BIT_WIDTH : width of dividend, divisor, quotient and remainder
//   PRECISION     : width of the reciprocal fraction (value = rec / 2^PRECISION)
//   CNT_W         : width of a bit-index counter over ARG_BIT_WIDTH bits
//   PROD_W        : width of the shared serial-multiplier product
package recip_div_pkg;

  localparam int unsigned ARG_BIT_WIDTH = 32;
  localparam int unsigned PRECISION     = 64;
  localparam int unsigned CNT_W         = $clog2(ARG_BIT_WIDTH);
  localparam int unsigned PROD_W        = PRECISION + ARG_BIT_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    MUL_Q,
    MUL_R,
    CORR,
    DONE
  } rqu_state_t;

endpackage

// File: rtl/recip_quotient_unit_mul.sv
// Radix-2 serial shift-add multiplier.
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_start     : clears the accumulator and begins a new product
//   i_mcand     : multiplicand, must be held stable while the product runs
//   i_mplier    : multiplier, one bit consumed per cycle (LSB first)
//   o_done      : high in the cycle whose edge adds the final partial product
//   o_prod_hi   : top MPLIER_W bits of the finished product (valid with o_done)
//   o_prod_lo   : low MPLIER_W bits of the finished product (valid with o_done)
// The product outputs are taken from the next-accumulator value so the caller
// can capture the result on the same edge that restarts the multiplier.
module shift_add_mul #(
  parameter int unsigned MCAND_W  = 64,
  parameter int unsigned MPLIER_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic [MCAND_W-1:0]  i_mcand,
  input  logic [MPLIER_W-1:0] i_mplier,
  output logic                o_done,
  output logic [MPLIER_W-1:0] o_prod_hi,
  output logic [MPLIER_W-1:0] o_prod_lo
);

  localparam int unsigned PW = MCAND_W + MPLIER_W;
  localparam int unsigned CW = $clog2(MPLIER_W);

  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic [PW-1:0] r_acc;
  logic [PW-1:0] w_addend;
  logic [PW-1:0] w_acc_next;
  logic          w_last;

  always_comb begin
    w_addend = '0;
    if (i_mplier[r_cnt]) begin
      w_addend = PW'(i_mcand) << r_cnt;
    end
    w_acc_next = r_acc + w_addend;
    w_last     = (r_cnt == CW'(MPLIER_W - 1));
  end

  assign o_done    = r_busy && w_last;
  assign o_prod_hi = w_acc_next[PW-1 -: MPLIER_W];
  assign o_prod_lo = w_acc_next[MPLIER_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_acc  <= '0;
    end else if (i_start) begin
      r_cnt  <= '0;
      r_busy <= 1'b1;
      r_acc  <= '0;
    end else if (r_busy) begin
      r_acc <= w_acc_next;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/recip_quotient_unit.sv
// Exact unsigned quotient/remainder from a precomputed fixed-point reciprocal.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : request handshake (a, b, rec captured on accept)
//   a, b                 : dividend, divisor
//   rec                  : reciprocal of b, floor(2^64/b)-1 .. floor(2^64/b)
//   out_valid / out_ready: result handshake
//   quotient, remainder  : floor(a/b), a mod b ('1 and a when b == 0)
//   dvz                  : divide-by-zero flag, qualified by out_valid
// q_est = (a*rec) >> 64 is at most one below the true quotient, so a single
// conditional correction after r_est = a - q_est*b yields the exact result.
module recip_quotient_unit
  import recip_div_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ARG_BIT_WIDTH-1:0] a,
  input  logic [ARG_BIT_WIDTH-1:0] b,
  input  logic [PRECISION-1:0]     rec,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ARG_BIT_WIDTH-1:0] quotient,
  output logic [ARG_BIT_WIDTH-1:0] remainder,
  output logic                     dvz
);

  rqu_state_t               r_state;
  logic                     r_in_ready;
  logic                     r_out_valid;
  logic [ARG_BIT_WIDTH-1:0] r_quotient;
  logic [ARG_BIT_WIDTH-1:0] r_remainder;
  logic                     r_dvz;
  logic [ARG_BIT_WIDTH-1:0] r_a;
  logic [ARG_BIT_WIDTH-1:0] r_b;
  logic [PRECISION-1:0]     r_rec;
  logic [ARG_BIT_WIDTH-1:0] r_q_est;
  logic [ARG_BIT_WIDTH-1:0] r_r_est;

  logic                     w_accept;
  logic                     w_mul_start;
  logic                     w_mul_done;
  logic [PRECISION-1:0]     w_mcand;
  logic [ARG_BIT_WIDTH-1:0] w_mplier;
  logic [ARG_BIT_WIDTH-1:0] w_prod_hi;
  logic [ARG_BIT_WIDTH-1:0] w_prod_lo;
  logic                     w_need_corr;

  assign w_accept = in_valid && r_in_ready;

  // One multiplier shared by both phases: rec x a, then q_est x b.
  // The MUL_R restart coincides with the last MUL_Q step.
  always_comb begin
    w_mcand     = PRECISION'(r_b);
    w_mplier    = r_q_est;
    if (r_state == MUL_Q) begin
      w_mcand  = r_rec;
      w_mplier = r_a;
    end
    w_mul_start = (w_accept && (b != '0)) || ((r_state == MUL_Q) && w_mul_done);
    w_need_corr = {1'b0, r_r_est} >= {1'b0, r_b};
  end

  shift_add_mul #(
    .MCAND_W  (PRECISION),
    .MPLIER_W (ARG_BIT_WIDTH)
  ) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_mul_start),
    .i_mcand   (w_mcand),
    .i_mplier  (w_mplier),
    .o_done    (w_mul_done),
    .o_prod_hi (w_prod_hi),
    .o_prod_lo (w_prod_lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dvz       <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_rec       <= '0;
      r_q_est     <= '0;
      r_r_est     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a        <= a;
            r_b        <= b;
            r_rec      <= rec;
            r_in_ready <= 1'b0;
            r_state    <= (b == '0) ? DONE : MUL_Q;
          end
        end
        MUL_Q: begin
          if (w_mul_done) begin
            r_q_est <= w_prod_hi;
            r_state <= MUL_R;
          end
        end
        MUL_R: begin
          // q_est*b never exceeds a, so only the low word matters.
          if (w_mul_done) begin
            r_r_est <= r_a - w_prod_lo;
            r_state <= CORR;
          end
        end
        CORR: begin
          if (w_need_corr) begin
            r_quotient  <= r_q_est + 1'b1;
            r_remainder <= r_r_est - r_b;
          end else begin
            r_quotient  <= r_q_est;
            r_remainder <= r_r_est;
          end
          r_dvz       <= 1'b0;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          // Entered without out_valid only on the divide-by-zero path.
          if (!r_out_valid) begin
            r_quotient  <= '1;
            r_remainder <= r_a;
            r_dvz       <= 1'b1;
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign dvz       = r_dvz;

endmodule

// File: tb/tb_recip_quotient_unit.sv
module tb_recip_quotient_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [63:0] rec;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        dvz;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] REC7 = 64'h2492492492492492;
  localparam logic [63:0] REC3 = 64'h5555555555555555;

  always #5 clk = ~clk;

  recip_quotient_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .rec       (rec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .dvz       (dvz)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Waits for in_ready, presents one request for a single edge, then counts
  // cycles until out_valid (bounded). lat is the number of edges after accept.
  task automatic issue(input logic [31:0] va, input logic [31:0] vb,
                       input logic [63:0] vr, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL issue_ready: in_ready=%0b required 1", in_ready);
    end
    a = va; b = vb; rec = vr; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = '0; b = '0; rec = '0;
    lat = 0;
    while (!out_valid && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; rec = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, dvz} !== 3'b100) begin
      errors++;
      $display("FAIL reset_flags: in_ready/out_valid/dvz=%b required 100", {in_ready, out_valid, dvz});
    end
    checks++;
    if ({quotient, remainder} !== 64'd0) begin
      errors++;
      $display("FAIL reset_data: q=%h r=%h required 0 0", quotient, remainder);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat;
    issue(32'd100, 32'd7, REC7, lat);
    checks++;
    if (lat !== 65) begin
      errors++;
      $display("FAIL basic_latency: got %0d required 65", lat);
    end
    checks++;
    if (quotient !== 32'd14 || remainder !== 32'd2 || dvz !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: q=%0d r=%0d dvz=%0b required 14 2 0", quotient, remainder, dvz);
    end
    release_out();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_handshake: out_valid=%0b in_ready=%0b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_correction();
    int lat;
    issue(32'd7, 32'd7, REC7, lat);
    checks++;
    if (lat !== 65 || quotient !== 32'd1 || remainder !== 32'd0) begin
      errors++;
      $display("FAIL corr_7_7: lat=%0d q=%0d r=%0d required 65 1 0", lat, quotient, remainder);
    end
    release_out();
  endtask

  task automatic test_b_one();
    int lat;
    issue(32'hFFFF_FFFF, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF, lat);
    checks++;
    if (quotient !== 32'hFFFF_FFFF || remainder !== 32'd0 || dvz !== 1'b0) begin
      errors++;
      $display("FAIL b_one: q=%h r=%h dvz=%0b required ffffffff 0 0", quotient, remainder, dvz);
    end
    release_out();
  endtask

  task automatic test_dvz();
    int lat;
    issue(32'h1234, 32'd0, 64'hDEAD_BEEF_0000_0001, lat);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL dvz_latency: got %0d required 1", lat);
    end
    checks++;
    if (dvz !== 1'b1 || quotient !== 32'hFFFF_FFFF || remainder !== 32'h1234) begin
      errors++;
      $display("FAIL dvz_result: dvz=%0b q=%h r=%h required 1 ffffffff 1234", dvz, quotient, remainder);
    end
    release_out();
  endtask

  task automatic test_zero_dividend();
    int lat;
    issue(32'd0, 32'd13, 64'h13B1_3B13_B13B_13B1, lat);
    checks++;
    if (quotient !== 32'd0 || remainder !== 32'd0 || lat !== 65) begin
      errors++;
      $display("FAIL zero_dividend: lat=%0d q=%0d r=%0d required 65 0 0", lat, quotient, remainder);
    end
    release_out();
  endtask

  task automatic test_backpressure();
    int lat;
    bit seen;
    issue(32'd1000, 32'd3, REC3, lat);
    checks++;
    if (quotient !== 32'd333 || remainder !== 32'd1) begin
      errors++;
      $display("FAIL bp_result: q=%0d r=%0d required 333 1", quotient, remainder);
    end
    a = 32'd5; b = 32'd0; rec = '0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 32'd333 ||
          remainder !== 32'd1 || dvz !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: ov=%0b ir=%0b q=%0d r=%0d dvz=%0b required 1 0 333 1 0",
                 i, out_valid, in_ready, quotient, remainder, dvz);
      end
    end
    in_valid = 1'b0;
    release_out();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%0b in_ready=%0b required 0 1", out_valid, in_ready);
    end
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL bp_not_queued: out_valid seen=%0b required 0", seen);
    end
  endtask

  task automatic test_reset_midop();
    bit seen;
    while (!in_ready) begin @(posedge clk); #1; end
    a = 32'd100; b = 32'd7; rec = REC7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (19) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || quotient !== 32'd0 || remainder !== 32'd0 ||
        dvz !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midop_reset: ov=%0b q=%0d r=%0d dvz=%0b ir=%0b required 0 0 0 0 1",
               out_valid, quotient, remainder, dvz, in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midop_stale: out_valid seen=%0b in_ready=%0b required 0 1", seen, in_ready);
    end
  endtask

  task automatic test_random();
    int lat;
    logic [31:0] va, vb;
    logic [63:0] vr;
    logic [64:0] full;
    for (int n = 0; n < 150; n++) begin
      va = $urandom;
      case (n % 3)
        0: vb = $urandom;
        1: vb = $urandom_range(1, 1000);
        default: vb = 32'd1 << $urandom_range(0, 31);
      endcase
      if (vb == 0) vb = 32'd1;
      full = 65'h1_0000_0000_0000_0000 / {33'd0, vb};
      if (n % 2 == 0) begin
        vr = (full > 65'h0_FFFF_FFFF_FFFF_FFFF) ? 64'hFFFF_FFFF_FFFF_FFFF : full[63:0];
      end else begin
        full = full - 65'd1;
        vr = full[63:0];
      end
      issue(va, vb, vr, lat);
      checks++;
      if (lat !== 65 || quotient !== va / vb || remainder !== va % vb || dvz !== 1'b0) begin
        errors++;
        $display("FAIL random[%0d] a=%h b=%h rec=%h: lat=%0d q=%h r=%h dvz=%0b required 65 %h %h 0",
                 n, va, vb, vr, lat, quotient, remainder, dvz, va / vb, va % vb);
      end
      release_out();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_correction();
    test_b_one();
    test_dvz();
    test_zero_dividend();
    test_backpressure();
    test_reset_midop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
